// File: rtl/fifo_b2s.sv
// fifo_b2s: 16-bit word FIFO unpacked into a 4-bit nibble stream.
// Define B2S_MSB_FIRST_EN to emit din[15:12] first instead of din[3:0].
module fifo_b2s #(
    parameter int DEPTH        = 8,
    parameter int PROG_FULL_TH = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        din_en,
    output logic        full,
    output logic        prog_full,
    output logic [3:0]  dout,
    output logic        dout_en,
    input  logic        rd_en,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_PROG = (AW+1)'(PROG_FULL_TH);
    localparam logic [AW:0] CNT_ZERO = '0;

    typedef enum logic {
        S_IDLE,
        S_VALID
    } state_t;

    logic [15:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic [15:0] sreg;
    logic [1:0]  idx;
    state_t      state;
    logic        wr_acc;
    logic        load;
    logic        have_word;

    assign have_word = (count != CNT_ZERO);
    assign full      = (count == CNT_FULL);
    assign prog_full = (count >= CNT_PROG);
    assign dout_en   = (state == S_VALID);
    assign empty     = !have_word && !dout_en;

    // full is sampled before any same-edge pop, so a pop never frees a slot early
    assign wr_acc = din_en && !full && !rst;

    // a word leaves the array when the unpacker is idle or finishing its last nibble
    always_comb begin
        load = 1'b0;
        if (have_word) begin
            unique case (state)
                S_IDLE:  load = 1'b1;
                S_VALID: load = rd_en && (idx == 2'd3);
            endcase
        end
    end

    // word storage; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    // write pointer and occupancy count; the count drives every flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            case ({wr_acc, load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // unpacker FSM: holds one word and steps through its nibbles on rd_en
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            idx    <= 2'd0;
            sreg   <= 16'h0000;
            rd_ptr <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (load) begin
                        sreg   <= mem[rd_ptr[AW-1:0]];
                        rd_ptr <= rd_ptr + 1'b1;
                        idx    <= 2'd0;
                        state  <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (rd_en) begin
                        if (idx != 2'd3) begin
                            idx <= idx + 2'd1;
                        end else if (load) begin
                            sreg   <= mem[rd_ptr[AW-1:0]];
                            rd_ptr <= rd_ptr + 1'b1;
                            idx    <= 2'd0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // nibble select from the held word
    always_comb begin
        dout = 4'h0;
        case (idx)
`ifdef B2S_MSB_FIRST_EN
            2'd0: dout = sreg[15:12];
            2'd1: dout = sreg[11:8];
            2'd2: dout = sreg[7:4];
            2'd3: dout = sreg[3:0];
`else
            2'd0: dout = sreg[3:0];
            2'd1: dout = sreg[7:4];
            2'd2: dout = sreg[11:8];
            2'd3: dout = sreg[15:12];
`endif
            default: dout = 4'h0;
        endcase
    end

endmodule

// File: tb/tb_fifo_b2s.sv
// tb_fifo_b2s: directed and random checks of fifo_b2s against a queue model.
// Model tracks stored words and pending nibbles; flags follow from their sizes.
module tb_fifo_b2s;

    localparam int DEPTH = 8;
    localparam int PFTH  = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = 16'h0;
    logic        din_en = 1'b0;
    logic        full;
    logic        prog_full;
    logic [3:0]  dout;
    logic        dout_en;
    logic        rd_en = 1'b0;
    logic        empty;

    int errors = 0;
    int checks = 0;

    logic [15:0] arr_q [$];
    logic [3:0]  cur_q [$];

    fifo_b2s #(.DEPTH(DEPTH), .PROG_FULL_TH(PFTH)) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .din_en(din_en),
        .full(full),
        .prog_full(prog_full),
        .dout(dout),
        .dout_en(dout_en),
        .rd_en(rd_en),
        .empty(empty)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] nib(input logic [15:0] w, input int i);
`ifdef B2S_MSB_FIRST_EN
        return w[(3-i)*4 +: 4];
`else
        return w[i*4 +: 4];
`endif
    endfunction

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_word();
        logic [15:0] w;
        w = arr_q.pop_front();
        for (int i = 0; i < 4; i++)
            cur_q.push_back(nib(w, i));
    endtask

    // one clock: drive, advance model with pre-edge state, compare after edge
    task automatic step(input logic de, input logic [15:0] d,
                        input logic re, input logic r);
        logic wr;
        logic [3:0] junk;
        din_en = de;
        din    = d;
        rd_en  = re;
        rst    = r;
        @(posedge clk);
        if (r) begin
            arr_q.delete();
            cur_q.delete();
        end else begin
            wr = de && (arr_q.size() < DEPTH);
            if (cur_q.size() == 0) begin
                if (arr_q.size() > 0)
                    load_word();
            end else if (re) begin
                junk = cur_q.pop_front();
                if (cur_q.size() == 0 && arr_q.size() > 0)
                    load_word();
            end
            if (wr)
                arr_q.push_back(d);
        end
        #1;
        check("dout_en", {15'h0, dout_en}, {15'h0, cur_q.size() != 0});
        check("full", {15'h0, full}, {15'h0, arr_q.size() == DEPTH});
        check("prog_full", {15'h0, prog_full}, {15'h0, arr_q.size() >= PFTH});
        check("empty", {15'h0, empty},
              {15'h0, arr_q.size() == 0 && cur_q.size() == 0});
        if (cur_q.size() != 0)
            check("dout", {12'h0, dout}, {12'h0, cur_q[0]});
    endtask

    task automatic idle(input int n, input logic re);
        for (int i = 0; i < n; i++)
            step(1'b0, 16'h0, re, 1'b0);
    endtask

    initial begin
        logic [15:0] w;

        // reset state
        step(1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("rst_dout", {12'h0, dout}, 16'h0);
        check("rst_empty", {15'h0, empty}, 16'h1);

        // single word, latency and order
        step(1'b1, 16'h4321, 1'b1, 1'b0);
        check("lat_n", {15'h0, dout_en}, 16'h0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        check("lat_n1", {15'h0, dout_en}, 16'h1);
        idle(5, 1'b1);
        check("single_empty", {15'h0, empty}, 16'h1);

        // fill past full with reader stalled, then drain
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 16'(i), 1'b0, 1'b0);
            if (i == 7)
                check("pf_at7", {15'h0, prog_full}, 16'h1);
            if (i == 9)
                check("full_at9", {15'h0, full}, 16'h1);
        end
        idle(40, 1'b1);
        check("drain_empty", {15'h0, empty}, 16'h1);

        // random words every 4th cycle with continuous reading
        for (int i = 0; i < 100; i++) begin
            w = 16'($urandom);
            step(1'b1, w, 1'b1, 1'b0);
            idle(3, 1'b1);
        end
        idle(8, 1'b1);

        // reader toggling each cycle
        step(1'b1, 16'hA5C3, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++)
            step(1'b0, 16'h0, i[0] ? 1'b0 : 1'b1, 1'b0);
        idle(4, 1'b1);

        // write at full on the same edge as last-nibble pop
        for (int i = 0; i < 9; i++)
            step(1'b1, 16'h1110 + 16'(i), 1'b0, 1'b0);
        check("pre_full", {15'h0, full}, 16'h1);
        idle(3, 1'b1);
        step(1'b1, 16'hDEAD, 1'b1, 1'b0);
        check("race_full", {15'h0, full}, 16'h0);
        idle(40, 1'b1);

        // reset mid-operation
        for (int i = 0; i < 6; i++)
            step(1'b1, 16'h2220 + 16'(i), 1'b0, 1'b0);
        idle(2, 1'b1);
        step(1'b1, 16'hBEEF, 1'b1, 1'b1);
        check("mid_rst_en", {15'h0, dout_en}, 16'h0);
        check("mid_rst_dout", {12'h0, dout}, 16'h0);
        check("mid_rst_empty", {15'h0, empty}, 16'h1);
        step(1'b1, 16'h00F0, 1'b1, 1'b0);
        idle(6, 1'b1);
        check("final_empty", {15'h0, empty}, 16'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_b2s.md
# fifo_b2s

Single-clock big-to-small width-conversion FIFO: accepts 16-bit words on the write side, buffers them, and emits them as four 4-bit nibbles on the read side under a read-enable handshake. It is the counterpart of the existing small-to-big converter `fifo_s2b` and unpacks the 16-bit words that block assembles back into the 4-bit stream.

## Interface
Parameters:
- DEPTH, 8, word-FIFO depth in 16-bit words; power of 2, minimum 4.
- PROG_FULL_TH, 6, word count at or above which prog_full asserts; valid range 1..DEPTH.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  16  write word.
- din_en  input  1  write strobe; din captured on the edge where din_en=1 and full=0.
- full  output  1  word FIFO holds DEPTH words.
- prog_full  output  1  word count >= PROG_FULL_TH.
- dout  output  4  current nibble; valid only when dout_en=1.
- dout_en  output  1  dout holds a valid nibble.
- rd_en  input  1  consumer accepts dout on an edge where dout_en=1.
- empty  output  1  no stored words and no nibble pending.

## Operation
- Storage: DEPTH x 16 array, wr_ptr/rd_ptr of log2(DEPTH)+1 bits (MSB = wrap bit), word count register 0..DEPTH.
- Write: on din_en && !full, mem[wr_ptr] <= din, wr_ptr++. Write while full is dropped silently; full is sampled before any same-cycle pop, so a pop does not make room for a write on that edge.
- Unpacker holds a 16-bit shift register and a 2-bit nibble index; two states:
  - IDLE (dout_en=0): if count>0, load mem[rd_ptr], rd_ptr++, idx<=0, go VALID.
  - VALID (dout_en=1): if rd_en: if idx<3, idx++ and dout advances to the next nibble; if idx==3 and count>0, load the next word with no bubble (idx<=0); if idx==3 and count==0, go IDLE. If !rd_en, hold dout and idx.
- Count update each edge: count <= count + write_accepted - word_loaded.
- Nibble order (default): din[3:0], din[7:4], din[11:8], din[15:12].
- Flags are decoded from registers only: full = (count==DEPTH); prog_full = (count>=PROG_FULL_TH); empty = (count==0) && !dout_en.
- Effective capacity is DEPTH+1 words: DEPTH in the array plus one in the unpacker.
- Pointer wrap: the index is ptr[log2(DEPTH)-1:0]; the wrap bit toggles on rollover and is not used for flags, because the count register is authoritative.

## Timing
- Reset (rst=1 at an edge): wr_ptr=rd_ptr=0, count=0, idx=0, state IDLE, dout=4'h0, dout_en=0, full=0, prog_full=0, empty=1. Array contents are not reset.
- Reset mid-operation discards all stored words and any pending nibble in the same edge, and takes priority over din_en and rd_en.
- Latency: word written at edge N -> count=1 after N -> unpacker loads at edge N+1 -> dout_en=1 and first nibble on dout after N+1.
- Throughput: one nibble per clock with rd_en held high and the FIFO non-empty; a word boundary costs no idle cycle.
- Flags update on the edge after the causing write or load.

## Configuration
- B2S_MSB_FIRST_EN:
  - Defined: nibbles are emitted din[15:12] first, then [11:8], [7:4], [3:0].
  - Undefined: LSB-first order, as in Operation.
- The macro affects only nibble selection. Latency, flags and handshake are identical in both builds.

## Test plan
- Reset then single write din=16'h4321, rd_en=1 -> dout_en rises 2 edges after the write; dout = 1,2,3,4 on consecutive cycles (4,3,2,1 with B2S_MSB_FIRST_EN); then dout_en=0, empty=1.
- rd_en=0, 10 back-to-back writes 16'h0001..16'h000A -> prog_full=1 after the 7th write, full=1 after the 9th; 10th dropped; then rd_en=1 yields words 1..9 only, 36 nibbles, then empty=1.
- Continuous writes every 4th cycle with rd_en=1 for 100 words of random data -> nibble stream matches the reference model exactly, dout_en never drops between words, full never asserts.
- rd_en toggled 1/0 every cycle during readout of 16'hA5C3 -> each nibble held while rd_en=0; sequence 3,C,5,A, nothing skipped or repeated.
- Write at full coinciding with last-nibble pop (count=8, idx=3, rd_en=1, din_en=1) -> write dropped, count=7 after the edge, full=0.
- rst=1 asserted with 5 words stored and idx=2 -> next cycle dout_en=0, dout=0, count=0, empty=1; a following write 16'h00F0 is read out as 0,F,0,0.
